// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared command, response and state definitions for the dht11 scheduler
package dht_pkg;

  localparam logic [7:0] CMD_STATUS   = 8'h00;
  localparam logic [7:0] CMD_TEMP     = 8'h01;
  localparam logic [7:0] CMD_HUM      = 8'h02;
  localparam logic [7:0] CMD_CONT_T   = 8'h03;
  localparam logic [7:0] CMD_CONT_H   = 8'h04;
  localparam logic [7:0] CMD_CONT_OFF = 8'h05;

  localparam logic [7:0] RSP_OK       = 8'h00;
  localparam logic [7:0] RSP_TEMP     = 8'h09;
  localparam logic [7:0] RSP_HUM      = 8'h08;
  localparam logic [7:0] RSP_CONT_OFF = 8'h0A;
  localparam logic [7:0] RSP_FAULT    = 8'h1F;
  localparam logic [7:0] RSP_INVALID  = 8'hFF;

  localparam logic [7:0] FLT_DRV      = 8'h01;
  localparam logic [7:0] FLT_CRC      = 8'h02;
  localparam logic [7:0] FLT_TIMEOUT  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GAP, ST_LAUNCH, ST_BUSY, ST_EVAL, ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    RD_STATUS, RD_TEMP, RD_HUM
  } rd_kind_t;

  // Commands 0x00..0x04 all start a sensor read.
  function automatic logic cmd_is_read(input logic [7:0] cmd);
    return cmd <= CMD_CONT_H;
  endfunction

endpackage

// File: rtl/dht_crc_chk.sv
// rtl/dht_crc_chk.sv - checks the dht11 checksum byte against the modulo-256 sum of the data bytes
module dht_crc_chk
  import dht_pkg::*;
(
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic [7:0] crc,
  output logic       ok
);

  logic [7:0] sum;

  assign sum = hum_int + hum_float + temp_int + temp_float;
  assign ok  = (sum == crc);

endmodule

// File: rtl/dht11_sched.sv
// rtl/dht11_sched.sv - dht11 transaction scheduler: commands, inter-read gap, fault classification, responses
module dht11_sched
  import dht_pkg::*;
#(
  parameter int MIN_GAP_CYC = 100000000,
  parameter int TIMEOUT_CYC = 25000000,
  parameter int START_CYC   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Cmd_Valid,
  input  logic [7:0] i_Cmd,
  output logic       o_Cmd_Ready,
  output logic       o_Rsp_Valid,
  output logic [7:0] o_Rsp_Code,
  output logic [7:0] o_Rsp_Data,
  input  logic       i_Rsp_Ready,
  output logic       o_Dht_En,
  output logic       o_Dht_Rst,
  input  logic       i_Dht_Wait,
  input  logic       i_Dht_Error,
  input  logic [7:0] i_Hum_Int,
  input  logic [7:0] i_Hum_Float,
  input  logic [7:0] i_Temp_Int,
  input  logic [7:0] i_Temp_Float,
  input  logic [7:0] i_Crc,
  output logic       o_Cont,
  output logic       o_Busy
);

  localparam logic [31:0] GAP_END    = 32'(MIN_GAP_CYC);
  localparam logic [31:0] TOUT_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] START_LAST = 32'(START_CYC);

  state_t      state, state_next;
  rd_kind_t    rd_kind, cont_kind;
  logic [31:0] gap_cnt, step_cnt;
  logic [7:0]  rsp_code, rsp_data;
  logic        gap_ok, accept, tout_hit, tout_seen, err_seen, crc_ok, cont, cmd_ready;

  assign gap_ok = (gap_cnt >= GAP_END);
  assign accept = cmd_ready && i_Cmd_Valid;

  dht_crc_chk u_crc (
    .hum_int    (i_Hum_Int),
    .hum_float  (i_Hum_Float),
    .temp_int   (i_Temp_Int),
    .temp_float (i_Temp_Float),
    .crc        (i_Crc),
    .ok         (crc_ok)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    tout_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept)             state_next = cmd_is_read(i_Cmd) ? ST_GAP : ST_RESP;
        else if (cont && gap_ok) state_next = ST_LAUNCH;
      end
      ST_GAP:    if (gap_ok) state_next = ST_LAUNCH;
      ST_LAUNCH: begin
        if (i_Dht_Wait) state_next = ST_BUSY;
        else if (step_cnt >= START_LAST) begin
          state_next = ST_EVAL;
          tout_hit   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!i_Dht_Wait) state_next = ST_EVAL;
        else if (step_cnt >= TOUT_LAST) begin
          state_next = ST_EVAL;
          tout_hit   = 1'b1;
        end
      end
      ST_EVAL: state_next = ST_RESP;
      ST_RESP: if (i_Rsp_Ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cmd_ready <= 1'b0;
      gap_cnt   <= '0;
      step_cnt  <= '0;
      tout_seen <= 1'b0;
      err_seen  <= 1'b0;
      cont      <= 1'b0;
      rd_kind   <= RD_STATUS;
      cont_kind <= RD_TEMP;
      rsp_code  <= 8'h00;
      rsp_data  <= 8'h00;
    end else begin
      cmd_ready <= (state_next == ST_IDLE);

      // Gap restarts when a read ends and saturates once elapsed.
      if (state_next == ST_EVAL) gap_cnt <= '0;
      else if (!gap_ok)          gap_cnt <= gap_cnt + 32'd1;

      if (state_next != state) step_cnt <= '0;
      else if (state == ST_LAUNCH || state == ST_BUSY) step_cnt <= step_cnt + 32'd1;

      if (state_next == ST_LAUNCH && state != ST_LAUNCH) begin
        tout_seen <= 1'b0;
        err_seen  <= 1'b0;
      end else begin
        if (tout_hit) tout_seen <= 1'b1;
        if (state == ST_BUSY && i_Dht_Error) err_seen <= 1'b1;
      end

      if (accept) begin
        case (i_Cmd)
          CMD_STATUS: rd_kind <= RD_STATUS;
          CMD_TEMP:   rd_kind <= RD_TEMP;
          CMD_HUM:    rd_kind <= RD_HUM;
          CMD_CONT_T: begin
            rd_kind   <= RD_TEMP;
            cont_kind <= RD_TEMP;
            cont      <= 1'b1;
          end
          CMD_CONT_H: begin
            rd_kind   <= RD_HUM;
            cont_kind <= RD_HUM;
            cont      <= 1'b1;
          end
          CMD_CONT_OFF: begin
            cont     <= 1'b0;
            rsp_code <= RSP_CONT_OFF;
            rsp_data <= 8'h00;
          end
          default: begin
            rsp_code <= RSP_INVALID;
            rsp_data <= i_Cmd;
          end
        endcase
      end else if (state == ST_IDLE && state_next == ST_LAUNCH) begin
        rd_kind <= cont_kind;
      end

      if (state == ST_EVAL) begin
        if (tout_seen) begin
          rsp_code <= RSP_FAULT;
          rsp_data <= FLT_TIMEOUT;
        end else if (err_seen) begin
          rsp_code <= RSP_FAULT;
          rsp_data <= FLT_DRV;
        end else if (!crc_ok) begin
          rsp_code <= RSP_FAULT;
          rsp_data <= FLT_CRC;
        end else begin
          case (rd_kind)
            RD_TEMP: begin
              rsp_code <= RSP_TEMP;
              rsp_data <= i_Temp_Int;
            end
            RD_HUM: begin
              rsp_code <= RSP_HUM;
              rsp_data <= i_Hum_Int;
            end
            default: begin
              rsp_code <= RSP_OK;
              rsp_data <= 8'h00;
            end
          endcase
        end
      end
    end
  end

  // Driver is released from reset only while a read is in flight.
  assign o_Dht_En    = 1'b1;
  assign o_Dht_Rst   = !(state == ST_LAUNCH || state == ST_BUSY);
  assign o_Cmd_Ready = cmd_ready;
  assign o_Rsp_Valid = (state == ST_RESP);
  assign o_Rsp_Code  = rsp_code;
  assign o_Rsp_Data  = rsp_data;
  assign o_Cont      = cont;
  assign o_Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dht11_sched.sv
// tb/tb_dht11_sched.sv - self-checking bench for dht11_sched with a behavioural sensor stub
module tb_dht11_sched;

  localparam int MIN_GAP = 100;
  localparam int TOUT    = 500;
  localparam int START   = 4;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Cmd_Valid = 1'b0;
  logic [7:0] i_Cmd = 8'h00;
  logic       o_Cmd_Ready, o_Rsp_Valid;
  logic [7:0] o_Rsp_Code, o_Rsp_Data;
  logic       i_Rsp_Ready = 1'b1;
  logic       o_Dht_En, o_Dht_Rst;
  logic       i_Dht_Wait = 1'b0;
  logic       i_Dht_Error = 1'b0;
  logic [7:0] i_Hum_Int = 8'h00, i_Hum_Float = 8'h00, i_Temp_Int = 8'h00, i_Temp_Float = 8'h00, i_Crc = 8'h00;
  logic       o_Cont, o_Busy;

  int vectors = 0;
  int miscompares = 0;

  int s_busy = 10;
  bit s_nostart = 1'b0;
  bit s_err = 1'b0;
  int scnt = 0;

  int  cyc = 0, last_rise = 0, last_fall = 0, gap_delta = 0;
  logic prev_rst = 1'b1;

  always #5 i_Clock = ~i_Clock;

  dht11_sched #(
    .MIN_GAP_CYC (MIN_GAP),
    .TIMEOUT_CYC (TOUT),
    .START_CYC   (START)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst_n      (i_Rst_n),
    .i_Cmd_Valid  (i_Cmd_Valid),
    .i_Cmd        (i_Cmd),
    .o_Cmd_Ready  (o_Cmd_Ready),
    .o_Rsp_Valid  (o_Rsp_Valid),
    .o_Rsp_Code   (o_Rsp_Code),
    .o_Rsp_Data   (o_Rsp_Data),
    .i_Rsp_Ready  (i_Rsp_Ready),
    .o_Dht_En     (o_Dht_En),
    .o_Dht_Rst    (o_Dht_Rst),
    .i_Dht_Wait   (i_Dht_Wait),
    .i_Dht_Error  (i_Dht_Error),
    .i_Hum_Int    (i_Hum_Int),
    .i_Hum_Float  (i_Hum_Float),
    .i_Temp_Int   (i_Temp_Int),
    .i_Temp_Float (i_Temp_Float),
    .i_Crc        (i_Crc),
    .o_Cont       (o_Cont),
    .o_Busy       (o_Busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Sensor stub: busy for s_busy cycles after release, one error pulse just before the end.
  always @(negedge i_Clock) begin
    if (o_Dht_Rst) begin
      scnt = 0;
      i_Dht_Wait = 1'b0;
      i_Dht_Error = 1'b0;
    end else begin
      scnt++;
      i_Dht_Wait = !s_nostart && (scnt <= s_busy);
      i_Dht_Error = s_err && (scnt == s_busy - 1);
    end
  end

  // Launch/park monitor; every launch must respect the gap since the previous park (or reset).
  always @(negedge i_Clock) begin
    if (!i_Rst_n) begin
      cyc = 0;
      last_rise = 0;
      prev_rst = 1'b1;
    end else begin
      cyc++;
      if (prev_rst && !o_Dht_Rst) begin
        last_fall = cyc;
        gap_delta = cyc - last_rise;
        check_range("launch_gap", gap_delta, MIN_GAP, 1000000);
      end
      if (!prev_rst && o_Dht_Rst) last_rise = cyc;
      prev_rst = o_Dht_Rst;
    end
  end

  function automatic logic [15:0] model(input logic [7:0] cmd, input logic [7:0] hi, input logic [7:0] hf,
                                        input logic [7:0] ti, input logic [7:0] tf, input logic [7:0] crc,
                                        input int busy, input bit nostart, input bit err);
    logic [7:0] sum;
    if (cmd == 8'h05) return 16'h0A00;
    if (cmd > 8'h05) return {8'hFF, cmd};
    if (nostart || busy > TOUT) return 16'h1F03;
    if (err) return 16'h1F01;
    sum = hi + hf + ti + tf;
    if (sum != crc) return 16'h1F02;
    if (cmd == 8'h01 || cmd == 8'h03) return {8'h09, ti};
    if (cmd == 8'h02 || cmd == 8'h04) return {8'h08, hi};
    return 16'h0000;
  endfunction

  task automatic set_stub(input logic [7:0] hi, input logic [7:0] hf, input logic [7:0] ti,
                          input logic [7:0] tf, input logic [7:0] crc, input int busy,
                          input bit nostart, input bit err);
    i_Hum_Int = hi;
    i_Hum_Float = hf;
    i_Temp_Int = ti;
    i_Temp_Float = tf;
    i_Crc = crc;
    s_busy = busy;
    s_nostart = nostart;
    s_err = err;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int n = 0;
    i_Cmd = c;
    i_Cmd_Valid = 1'b1;
    while (!o_Cmd_Ready && n < 2000) begin
      @(negedge i_Clock);
      n++;
    end
    if (!o_Cmd_Ready) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_accept: o_Cmd_Ready=0 after 2000 cycles, required 1");
    end
    @(negedge i_Clock);
    i_Cmd_Valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [15:0] r);
    int n = 0;
    while (!o_Rsp_Valid && n < 2000) begin
      @(negedge i_Clock);
      n++;
    end
    if (!o_Rsp_Valid) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_wait: o_Rsp_Valid=0 after 2000 cycles, required 1");
    end
    r = {o_Rsp_Code, o_Rsp_Data};
  endtask

  task automatic get_rsp(output logic [15:0] r);
    wait_rsp(r);
    @(negedge i_Clock);
  endtask

  typedef struct {
    logic [7:0]  cmd, hi, hf, ti, tf, crc;
    int          busy;
    bit          nostart, err;
    logic [15:0] exp;
    int          dur_lo, dur_hi;
  } vec_t;

  initial begin
    vec_t        tbl[10];
    logic [15:0] r;
    logic [7:0]  c, hi, hf, ti, tf, crc;
    int          n, bad, k, busy;
    bit          e;

    tbl[0] = '{8'h01, 8'h37, 8'h00, 8'h1A, 8'h00, 8'h50, 20,  1'b0, 1'b0, 16'h1F02, 0, 1000};
    tbl[1] = '{8'h01, 8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 20,  1'b0, 1'b1, 16'h1F01, 0, 1000};
    tbl[2] = '{8'h01, 8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 600, 1'b0, 1'b0, 16'h1F03, TOUT, TOUT + 2};
    tbl[3] = '{8'h01, 8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 20,  1'b1, 1'b0, 16'h1F03, START + 1, START + 2};
    tbl[4] = '{8'h00, 8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 15,  1'b0, 1'b0, 16'h0000, 0, 1000};
    tbl[5] = '{8'h02, 8'h2D, 8'h05, 8'h17, 8'h03, 8'h4C, 40,  1'b0, 1'b0, 16'h082D, 0, 1000};
    tbl[6] = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10,  1'b0, 1'b0, 16'hFF42, 0, 1000};
    tbl[7] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10,  1'b0, 1'b0, 16'h0A00, 0, 1000};
    tbl[8] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10,  1'b0, 1'b0, 16'hFFFF, 0, 1000};
    tbl[9] = '{8'h01, 8'hF0, 8'h20, 8'h15, 8'h0B, 8'h30, 25,  1'b0, 1'b0, 16'h0915, 0, 1000};

    set_stub(8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 20, 1'b0, 1'b0);
    repeat (3) @(negedge i_Clock);
    check("rst_cmd_ready", o_Cmd_Ready, 0);
    check("rst_rsp_valid", o_Rsp_Valid, 0);
    check("rst_rsp", {o_Rsp_Code, o_Rsp_Data}, 16'h0000);
    check("rst_cont", o_Cont, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_dht_en", o_Dht_En, 1);
    check("rst_dht_rst", o_Dht_Rst, 1);
    #2 i_Rst_n = 1'b1;

    repeat (5) @(negedge i_Clock);
    send_cmd(8'h01);
    get_rsp(r);
    check("good_read", r, 16'h091A);
    check_range("first_launch", last_fall, MIN_GAP, MIN_GAP + 3);
    check("parked_after", o_Dht_Rst, 1);

    for (int i = 0; i < 10; i++) begin
      set_stub(tbl[i].hi, tbl[i].hf, tbl[i].ti, tbl[i].tf, tbl[i].crc, tbl[i].busy, tbl[i].nostart, tbl[i].err);
      send_cmd(tbl[i].cmd);
      if (tbl[i].cmd > 8'h04) check($sformatf("tbl%0d_latency", i), o_Rsp_Valid, 1);
      get_rsp(r);
      check($sformatf("tbl%0d_rsp", i), r, tbl[i].exp);
      if (tbl[i].cmd <= 8'h04)
        check_range($sformatf("tbl%0d_dur", i), last_rise - last_fall, tbl[i].dur_lo, tbl[i].dur_hi);
    end

    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 7);
      if (k < 3) c = k[7:0];
      else if (k == 3) c = 8'h05;
      else c = 8'($urandom_range(6, 255));
      hi = 8'($urandom);
      hf = 8'($urandom);
      ti = 8'($urandom);
      tf = 8'($urandom);
      crc = hi + hf + ti + tf;
      if ($urandom_range(0, 3) == 0) crc = crc + 8'($urandom_range(1, 255));
      e = ($urandom_range(0, 4) == 0);
      busy = $urandom_range(3, 200);
      set_stub(hi, hf, ti, tf, crc, busy, 1'b0, e);
      send_cmd(c);
      get_rsp(r);
      check($sformatf("rand%0d_cmd%02h", i, c), r, model(c, hi, hf, ti, tf, crc, busy, 1'b0, e));
    end

    set_stub(8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 20, 1'b0, 1'b0);
    send_cmd(8'h01);
    get_rsp(r);
    check("pre_gap_read", r, 16'h091A);
    set_stub(8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 30, 1'b0, 1'b0);
    i_Rsp_Ready = 1'b0;
    send_cmd(8'h02);
    wait_rsp(r);
    check_range("gap_delay", gap_delta, MIN_GAP, MIN_GAP + 3);
    bad = 0;
    repeat (50) begin
      @(negedge i_Clock);
      if (!o_Rsp_Valid || {o_Rsp_Code, o_Rsp_Data} !== 16'h0837 || o_Cmd_Ready) bad++;
    end
    check("stall_hold", bad, 0);
    check("stall_rsp", r, 16'h0837);
    i_Rsp_Ready = 1'b1;
    @(negedge i_Clock);
    check("stall_release", o_Rsp_Valid, 0);

    set_stub(8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 20, 1'b0, 1'b0);
    send_cmd(8'h04);
    get_rsp(r);
    check("cont_first", r, 16'h0837);
    check("cont_flag", o_Cont, 1);
    get_rsp(r);
    check("cont_auto1", r, 16'h0837);
    check_range("cont_gap", gap_delta, MIN_GAP, MIN_GAP + 3);
    send_cmd(8'h42);
    check("cont_inv_latency", o_Rsp_Valid, 1);
    get_rsp(r);
    check("cont_invalid", r, 16'hFF42);
    get_rsp(r);
    check("cont_auto2", r, 16'h0837);
    send_cmd(8'h05);
    get_rsp(r);
    check("cont_off", r, 16'h0A00);
    check("cont_cleared", o_Cont, 0);
    n = 0;
    repeat (300) begin
      @(negedge i_Clock);
      if (o_Rsp_Valid) n++;
    end
    check("cont_quiet", n, 0);

    set_stub(8'h37, 8'h00, 8'h1A, 8'h00, 8'h51, 200, 1'b0, 1'b0);
    send_cmd(8'h03);
    n = 0;
    while (o_Dht_Rst && n < 500) begin
      @(negedge i_Clock);
      n++;
    end
    check("mid_launch", o_Dht_Rst, 0);
    repeat (20) @(negedge i_Clock);
    check("mid_busy", o_Busy, 1);
    check("mid_cont", o_Cont, 1);
    #2 i_Rst_n = 1'b0;
    #1;
    check("arst_dht_rst", o_Dht_Rst, 1);
    check("arst_busy", o_Busy, 0);
    check("arst_cont", o_Cont, 0);
    check("arst_rsp_valid", o_Rsp_Valid, 0);
    repeat (3) @(negedge i_Clock);
    #2 i_Rst_n = 1'b1;
    n = 0;
    repeat (250) begin
      @(negedge i_Clock);
      if (o_Rsp_Valid) n++;
    end
    check("arst_no_rsp", n, 0);
    check("arst_parked", o_Dht_Rst, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/dht11_sched.md
Name: dht11_sched

Overview:
- Transaction controller between the UART command decoder and the dht11 driver.
- Accepts one-byte commands, parks the driver between reads, and enforces the sensor's minimum inter-read gap.
- Runs a read, checks the checksum, classifies faults, and returns a two-byte response (code, data) with valid/ready handshakes.
- Supports an optional continuous mode that re-issues reads automatically.

Parameters:
- MIN_GAP_CYC, 100000000, minimum cycles from end of one read to start of the next (2 s at 50 MHz); also applied after reset.
- TIMEOUT_CYC, 25000000, maximum cycles a read may keep i_Dht_Wait high before a timeout fault.
- START_CYC, 4, maximum cycles after releasing o_Dht_Rst for i_Dht_Wait to rise.

Ports:
- i_Clock  in  1  system clock, 50 MHz
- i_Rst_n  in  1  asynchronous active-low reset
- i_Cmd_Valid  in  1  command byte valid
- i_Cmd  in  8  command byte
- o_Cmd_Ready  out  1  command accepted when high with i_Cmd_Valid
- o_Rsp_Valid  out  1  response valid
- o_Rsp_Code  out  8  response code
- o_Rsp_Data  out  8  response data
- i_Rsp_Ready  in  1  response consumer ready
- o_Dht_En  out  1  driver enable
- o_Dht_Rst  out  1  driver reset (high = parked, bus released high)
- i_Dht_Wait  in  1  driver busy
- i_Dht_Error  in  1  driver error
- i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float, i_Crc  in  8 each  driver data bytes
- o_Cont  out  1  continuous mode active
- o_Busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - o_Dht_En=1, o_Dht_Rst=1.
  - o_Cmd_Ready=0, o_Rsp_Valid=0, code/data=0x00.
  - o_Cont=0, o_Busy=0.
  - gap counter=0, so the first read waits the full MIN_GAP_CYC.
- Commands (accepted only in IDLE, where o_Cmd_Ready=1):
  - 0x00 status read
  - 0x01 temperature read
  - 0x02 humidity read
  - 0x03 continuous temperature on
  - 0x04 continuous humidity on
  - 0x05 continuous off
  - anything else: invalid
- Response codes:
  - 0x00 status OK, data 0x00
  - 0x09 temperature, data = Temp_Int
  - 0x08 humidity, data = Hum_Int
  - 0x0A continuous-off ack, data 0x00
  - 0x1F fault, data = reason: 0x01 driver error, 0x02 CRC mismatch, 0x03 timeout/no start
  - 0xFF invalid command, data = the offending byte
- Continuous-on commands immediately perform one read of the selected quantity. Thereafter, in IDLE with gap elapsed and no command pending, a read of the stored quantity is auto-issued. A command pending in the same cycle has priority over an auto read.
- Gap counter: saturating; cleared when a read ends (EVAL entry); "elapsed" means count ≥ MIN_GAP_CYC.
- FSM states:
  - IDLE: accept a command, or start an auto read. Invalid and 0x05 commands go directly to RESP; 0x05 also clears o_Cont.
  - GAP: wait until the gap has elapsed.
  - LAUNCH: o_Dht_Rst=0; count cycles. i_Dht_Wait=1 goes to BUSY; more than START_CYC cycles goes to EVAL with fault 0x03.
  - BUSY: sticky-latch i_Dht_Error. i_Dht_Wait falling goes to EVAL. Reaching TIMEOUT_CYC cycles goes to EVAL with fault 0x03.
  - EVAL (1 cycle): o_Dht_Rst=1 (re-parked); capture data bytes. Fault priority: timeout > driver error > (Hum_Int+Hum_Float+Temp_Int+Temp_Float) mod 256 ≠ Crc.
  - RESP: hold o_Rsp_Valid with stable code/data until i_Rsp_Ready=1, then return to IDLE.
- Latency:
  - Read: response appears one cycle after EVAL.
  - Invalid/0x05 command: o_Rsp_Valid rises the cycle after acceptance.
- Continuous mode survives faults; every auto read produces a response. Auto reads pause while RESP is stalled; no responses are dropped.
- Asynchronous reset mid-read: everything returns to reset values immediately and the driver is parked. The bus is released through driver reset.

Decomposition:
- Shared package dht_pkg holds:
  - command constants CMD_STATUS, CMD_TEMP, CMD_HUM, CMD_CONT_T, CMD_CONT_H, CMD_CONT_OFF
  - response codes RSP_OK, RSP_TEMP, RSP_HUM, RSP_CONT_OFF, RSP_FAULT, RSP_INVALID
  - fault reasons
  - state encoding
- One sub-module is natural: dht_crc_chk, combinational 4-byte sum compare.

Test Plan:
Bench uses MIN_GAP_CYC=100, TIMEOUT_CYC=500 and a behavioural dht11 stub with a programmable busy length and data.
- Good read: after reset, send 0x01 at cycle 5 with stub data 0x37,0x00,0x1A,0x00,0x51 → o_Dht_Rst falls no earlier than cycle 100; response 0x09/0x1A; o_Dht_Rst=1 afterwards.
- CRC and error faults: stub Crc=0x50 → 0x1F/0x02. Stub pulses error during busy, then clears it before wait falls → 0x1F/0x01.
- Timeout and no-start: stub holds wait high for 600 cycles → 0x1F/0x03 at 500 cycles. Stub never raises wait → 0x1F/0x03 after 4 cycles.
- Gap and backpressure: second 0x02 issued right after the first response → launch is delayed until 100 cycles after EVAL. Holding i_Rsp_Ready=0 for 50 cycles keeps 0x08/0x37 stable; o_Cmd_Ready=0 throughout.
- Continuous mode and invalid command: 0x04 → humidity responses every ~100+busy cycles; command 0x42 → 0xFF/0x42 ahead of the next auto read; 0x05 → 0x0A/0x00 and o_Cont=0.
- Reset mid-BUSY: assert i_Rst_n=0 → o_Dht_Rst=1 and o_Busy=0 asynchronously; no response; o_Cont=0.
